// File: rtl/alu_operand_stage.sv
// Decode/issue stage feeding the ALU: decodes the instruction into an ALU operation
// and operands, then holds the results in a 2-entry skid buffer (main + skid).
module alu_operand_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [4:0]  rd,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  operation,
  output logic [31:0] ALU_in_X,
  output logic [31:0] ALU_in_Y,
  output logic [4:0]  rd_out,
  output logic        illegal
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  rd;
    logic        illegal;
  } entry_t;

  entry_t dec;
  entry_t main_reg, main_next;
  entry_t skid_reg, skid_next;
  logic   main_full_reg, main_full_next;
  logic   skid_full_reg, skid_full_next;
  logic   accept;
  logic   consume;

  always_comb begin
    dec         = '0;
    dec.rd      = rd;
    dec.op      = OP_ADD;
    dec.x       = rs1_data;
    dec.y       = rs2_data;
    dec.illegal = 1'b0;
    case (opcode)
      OPC_R: begin
        case (funct3)
          3'b000:  dec.op = funct7_5 ? OP_SUB : OP_ADD;
          3'b111:  dec.op = OP_AND;
          3'b110:  dec.op = OP_OR;
          3'b010:  dec.op = OP_SLT;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_I: begin
        dec.y = imm;
        case (funct3)
          3'b000:  dec.op = OP_ADD;
          3'b111:  dec.op = OP_AND;
          3'b110:  dec.op = OP_OR;
          3'b010:  dec.op = OP_SLT;
          default: dec.illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_STORE: dec.y = imm;
      // BEQ/BNE are resolved from the ALU zero flag of rs1 - rs2.
      OPC_BRANCH: dec.op = OP_SUB;
      OPC_LUI: begin
        dec.x = '0;
        dec.y = imm;
      end
      OPC_AUIPC: begin
        dec.x = pc;
        dec.y = imm;
      end
      OPC_JAL, OPC_JALR: begin
        dec.x = pc;
        dec.y = 32'd4;
      end
      default: dec.illegal = 1'b1;
    endcase
    // Illegal entries still flow downstream, but with neutral operands.
    if (dec.illegal) begin
      dec.op = OP_ADD;
      dec.x  = '0;
      dec.y  = '0;
    end
  end

  // A full skid always blocks input, so accept and skid drain never coincide.
  assign accept  = in_valid && !skid_full_reg;
  assign consume = main_full_reg && out_ready;

  always_comb begin
    main_next      = main_reg;
    skid_next      = skid_reg;
    main_full_next = main_full_reg;
    skid_full_next = skid_full_reg;
    if (flush) begin
      main_full_next = 1'b0;
      skid_full_next = 1'b0;
    end else if (consume && skid_full_reg) begin
      main_next      = skid_reg;
      skid_full_next = 1'b0;
    end else if (accept && (!main_full_reg || consume)) begin
      main_next      = dec;
      main_full_next = 1'b1;
    end else if (accept) begin
      skid_next      = dec;
      skid_full_next = 1'b1;
    end else if (consume) begin
      main_full_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_reg      <= '0;
      skid_reg      <= '0;
      main_full_reg <= 1'b0;
      skid_full_reg <= 1'b0;
    end else begin
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      main_full_reg <= main_full_next;
      skid_full_reg <= skid_full_next;
    end
  end

  assign in_ready  = !skid_full_reg;
  assign out_valid = main_full_reg;
  assign operation = main_reg.op;
  assign ALU_in_X  = main_reg.x;
  assign ALU_in_Y  = main_reg.y;
  assign rd_out    = main_reg.rd;
  assign illegal   = main_reg.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: decode table plus backpressure, flush and
// reset-mid-stall sequences.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  logic [4:0]  rd;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic        out_valid, out_ready;
  logic [3:0]  operation;
  logic [31:0] ALU_in_X, ALU_in_Y;
  logic [4:0]  rd_out;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] seen_q[$];

  always #5 clk = ~clk;

  alu_operand_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .out_valid(out_valid), .out_ready(out_ready), .operation(operation),
    .ALU_in_X(ALU_in_X), .ALU_in_Y(ALU_in_Y), .rd_out(rd_out), .illegal(illegal)
  );

  // Record X of every entry consumed by the execute stage.
  always @(posedge clk)
    if (out_valid && out_ready) seen_q.push_back(ALU_in_X);

  typedef struct {
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [31:0] p;
    logic [3:0]  exp_op;
    logic [31:0] exp_x;
    logic [31:0] exp_y;
    logic        exp_ill;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_add(input logic [31:0] a);
    opcode = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b0;
    rs1_data = a; rs2_data = 32'd1; imm = 32'd0; pc = 32'd0; rd = 5'd3;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_illegal"}, {31'd0, illegal}, 32'd0);
    check({tag, "_operation"}, {28'd0, operation}, 32'd0);
    check({tag, "_x"}, ALU_in_X, 32'd0);
    check({tag, "_y"}, ALU_in_Y, 32'd0);
    check({tag, "_rd_out"}, {27'd0, rd_out}, 32'd0);
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0]  = '{7'b0110011, 3'b000, 1'b0, 32'd2565, 32'd1560, 32'd0, 32'd0, 4'b0010, 32'd2565, 32'd1560, 1'b0};
    vecs[1]  = '{7'b0110011, 3'b000, 1'b1, 32'd2565, 32'd1560, 32'd0, 32'd0, 4'b0110, 32'd2565, 32'd1560, 1'b0};
    vecs[2]  = '{7'b0110011, 3'b010, 1'b0, 32'd2565, 32'd1560, 32'd0, 32'd0, 4'b0111, 32'd2565, 32'd1560, 1'b0};
    vecs[3]  = '{7'b0110011, 3'b111, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 4'b0000, 32'hF0F0, 32'h0FF0, 1'b0};
    vecs[4]  = '{7'b0110011, 3'b110, 1'b0, 32'h1234, 32'h4321, 32'd0, 32'd0, 4'b0001, 32'h1234, 32'h4321, 1'b0};
    vecs[5]  = '{7'b0010011, 3'b110, 1'b0, 32'd2565, 32'd99, 32'd1560, 32'd0, 4'b0001, 32'd2565, 32'd1560, 1'b0};
    vecs[6]  = '{7'b0010011, 3'b000, 1'b1, 32'd7, 32'd99, 32'hFFFF_FFF0, 32'd0, 4'b0010, 32'd7, 32'hFFFF_FFF0, 1'b0};
    vecs[7]  = '{7'b0010011, 3'b010, 1'b0, 32'd5, 32'd99, 32'd9, 32'd0, 4'b0111, 32'd5, 32'd9, 1'b0};
    vecs[8]  = '{7'b0000011, 3'b010, 1'b0, 32'h1000, 32'd99, 32'd8, 32'd0, 4'b0010, 32'h1000, 32'd8, 1'b0};
    vecs[9]  = '{7'b0100011, 3'b010, 1'b0, 32'h2000, 32'd99, 32'd12, 32'd0, 4'b0010, 32'h2000, 32'd12, 1'b0};
    vecs[10] = '{7'b1100011, 3'b000, 1'b0, 32'd40, 32'd40, 32'd16, 32'd0, 4'b0110, 32'd40, 32'd40, 1'b0};
    vecs[11] = '{7'b0110111, 3'b000, 1'b0, 32'd55, 32'd66, 32'h12345000, 32'h80, 4'b0010, 32'd0, 32'h12345000, 1'b0};
    vecs[12] = '{7'b0010111, 3'b000, 1'b0, 32'd55, 32'd66, 32'h2000, 32'h100, 4'b0010, 32'h100, 32'h2000, 1'b0};
    vecs[13] = '{7'b1101111, 3'b000, 1'b0, 32'd55, 32'd66, 32'h40, 32'h200, 4'b0010, 32'h200, 32'd4, 1'b0};
    vecs[14] = '{7'b1100111, 3'b000, 1'b0, 32'd55, 32'd66, 32'h40, 32'h300, 4'b0010, 32'h300, 32'd4, 1'b0};
    vecs[15] = '{7'b0110011, 3'b001, 1'b0, 32'd55, 32'd66, 32'd0, 32'd0, 4'b0010, 32'd0, 32'd0, 1'b1};
    vecs[16] = '{7'b0010011, 3'b101, 1'b0, 32'd55, 32'd66, 32'd3, 32'd0, 4'b0010, 32'd0, 32'd0, 1'b1};
    vecs[17] = '{7'b1110011, 3'b000, 1'b0, 32'd55, 32'd66, 32'd3, 32'h44, 4'b0010, 32'd0, 32'd0, 1'b1};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_add(32'd0);
    step();
    step();
    check_reset_state("reset");
    @(negedge clk) reset = 1'b0;

    // Back-to-back stream with out_ready high: one result per cycle, in_ready never drops.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      opcode = vecs[i].opc; funct3 = vecs[i].f3; funct7_5 = vecs[i].f7;
      rs1_data = vecs[i].a; rs2_data = vecs[i].b; imm = vecs[i].im; pc = vecs[i].p;
      rd = 5'(i + 1); in_valid = 1'b1;
      step();
      $display("vec %0d: opcode=%b funct3=%b op=%b X=%0h Y=%0h illegal=%0b",
               i, vecs[i].opc, vecs[i].f3, operation, ALU_in_X, ALU_in_Y, illegal);
      check($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      check($sformatf("vec%0d_operation", i), {28'd0, operation}, {28'd0, vecs[i].exp_op});
      check($sformatf("vec%0d_x", i), ALU_in_X, vecs[i].exp_x);
      check($sformatf("vec%0d_y", i), ALU_in_Y, vecs[i].exp_y);
      check($sformatf("vec%0d_illegal", i), {31'd0, illegal}, {31'd0, vecs[i].exp_ill});
      check($sformatf("vec%0d_rd_out", i), {27'd0, rd_out}, 32'(i + 1));
    end
    @(negedge clk) in_valid = 1'b0;
    step();
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A, B, C offered while stalled; C must wait.
    seen_q.delete();
    @(negedge clk) begin out_ready = 1'b0; set_add(32'hA); in_valid = 1'b1; end
    step();
    $display("bp: accepted A, X=%0h in_ready=%0b", ALU_in_X, in_ready);
    check("bp_a_valid", {31'd0, out_valid}, 32'd1);
    check("bp_a_x", ALU_in_X, 32'hA);
    check("bp_a_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) set_add(32'hB);
    step();
    $display("bp: accepted B into skid, X=%0h in_ready=%0b", ALU_in_X, in_ready);
    check("bp_b_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_b_hold_x", ALU_in_X, 32'hA);
    @(negedge clk) set_add(32'hC);
    step();
    $display("bp: C held upstream, X=%0h in_ready=%0b", ALU_in_X, in_ready);
    check("bp_c_in_ready", {31'd0, in_ready}, 32'd0);
    check("bp_c_hold_x", ALU_in_X, 32'hA);
    check("bp_c_hold_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk) out_ready = 1'b1;
    step();
    $display("bp: released, X=%0h in_ready=%0b", ALU_in_X, in_ready);
    check("bp_rel1_x", ALU_in_X, 32'hB);
    check("bp_rel1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    $display("bp: C accepted, X=%0h", ALU_in_X);
    check("bp_rel2_x", ALU_in_X, 32'hC);
    check("bp_rel2_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk) in_valid = 1'b0;
    step();
    check("bp_empty_valid", {31'd0, out_valid}, 32'd0);
    repeat (2) step();
    check("bp_seen_count", 32'(seen_q.size()), 32'd3);
    if (seen_q.size() == 3) begin
      check("bp_seen0", seen_q[0], 32'hA);
      check("bp_seen1", seen_q[1], 32'hB);
      check("bp_seen2", seen_q[2], 32'hC);
    end

    // Flush with both entries held and a new offer in the same cycle.
    seen_q.delete();
    @(negedge clk) begin out_ready = 1'b0; set_add(32'hD); in_valid = 1'b1; end
    step();
    @(negedge clk) set_add(32'hE);
    step();
    check("fl_full_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk) begin flush = 1'b1; set_add(32'hF); end
    step();
    $display("flush: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk) begin flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; end
    repeat (3) step();
    check("fl_no_stale", 32'(seen_q.size()), 32'd0);
    check("fl_idle_valid", {31'd0, out_valid}, 32'd0);

    // Illegal entry stalls at the output, a second entry fills skid, then reset.
    seen_q.delete();
    @(negedge clk) begin
      out_ready = 1'b0; in_valid = 1'b1;
      opcode = 7'b0110011; funct3 = 3'b001; funct7_5 = 1'b0;
      rs1_data = 32'h77; rs2_data = 32'h88; imm = 32'd0; pc = 32'd0; rd = 5'd9;
    end
    step();
    $display("illegal: illegal=%0b X=%0h Y=%0h rd_out=%0d", illegal, ALU_in_X, ALU_in_Y, rd_out);
    check("ill_valid", {31'd0, out_valid}, 32'd1);
    check("ill_flag", {31'd0, illegal}, 32'd1);
    check("ill_x", ALU_in_X, 32'd0);
    check("ill_y", ALU_in_Y, 32'd0);
    check("ill_rd_out", {27'd0, rd_out}, 32'd9);
    @(negedge clk) set_add(32'h55);
    step();
    @(negedge clk) begin reset = 1'b1; in_valid = 1'b0; end
    step();
    $display("reset mid-stall: out_valid=%0b in_ready=%0b", out_valid, in_ready);
    check_reset_state("rst_stall");
    @(negedge clk) begin reset = 1'b0; out_ready = 1'b1; end
    repeat (3) step();
    check("rst_no_stale", 32'(seen_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
